lsu_ctrl: RTL and testbench

Load/store control unit between the execute stage and `data_mem`. It accepts one memory operation per handshake and checks alignment and range. It drives word-addressed, byte-enabled accesses to the data memory, then aligns and sign/zero-extends load data for writeback. It replaces per-lane case logic in the memory path: byte-lane selection is done here, from the request address only.

---
 rtl/lsu_ctrl_if.sv | 45 ++++
 rtl/lsu_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Bundle between execute, lsu_ctrl and data memory: request, memory access, writeback and exception.
// The slave modport is the unit's view; the master modport is the environment's view.
interface lsu_ctrl_if #(
    parameter int ADDR_W = 17
);
    // req_valid/req_ready: an op transfers on a rising edge where both are high;
    // req_* must be stable only on that edge, and the unit ignores req_valid while req_ready is low.
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_alucode;
    logic              req_is_load;
    logic              req_is_store;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;

    logic              mem_re;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;

    logic              exc_valid;
    logic [1:0]        exc_cause;
    logic [31:0]       exc_addr;

    modport slave (
        input  req_valid, req_alucode, req_is_load, req_is_store, req_addr, req_wdata, req_rd,
        input  mem_rdata,
        output req_ready, mem_re, mem_we, mem_be, mem_addr, mem_wdata,
        output wb_valid, wb_rd, wb_data, exc_valid, exc_cause, exc_addr
    );

    modport master (
        output req_valid, req_alucode, req_is_load, req_is_store, req_addr, req_wdata, req_rd,
        output mem_rdata,
        input  req_ready, mem_re, mem_we, mem_be, mem_addr, mem_wdata,
        input  wb_valid, wb_rd, wb_data, exc_valid, exc_cause, exc_addr
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control: classifies one request, drives a byte-enabled word access,
// then lane-selects and extends load data for writeback or reports a fault.
module lsu_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_ctrl_if.slave  bus,
    output logic [2:0] dbg_state
);
    localparam logic [5:0] ALU_LB  = 6'd18;
    localparam logic [5:0] ALU_LH  = 6'd19;
    localparam logic [5:0] ALU_LW  = 6'd20;
    localparam logic [5:0] ALU_LBU = 6'd21;
    localparam logic [5:0] ALU_LHU = 6'd22;
    localparam logic [5:0] ALU_SB  = 6'd23;
    localparam logic [5:0] ALU_SH  = 6'd24;
    localparam logic [5:0] ALU_SW  = 6'd25;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t      state, next_state;
    logic [5:0]  op_code;
    logic        op_load;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [4:0]  op_rd;
    logic [1:0]  op_cause;
    logic [31:0] load_data;

    logic        accept;
    logic        ld_code, st_code, legal, misaligned, out_of_range;
    logic [1:0]  req_width, op_width, req_cause;
    logic [31:0] lane;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;

    // 0 = byte, 1 = halfword, 2 = word
    function automatic logic [1:0] width_of(input logic [5:0] code);
        case (code)
            ALU_LB, ALU_LBU, ALU_SB: return 2'd0;
            ALU_LH, ALU_LHU, ALU_SH: return 2'd1;
            default:                 return 2'd2;
        endcase
    endfunction

    always_comb begin
        ld_code      = bus.req_alucode inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
        st_code      = bus.req_alucode inside {ALU_SB, ALU_SH, ALU_SW};
        legal        = (bus.req_is_load && !bus.req_is_store && ld_code) ||
                       (bus.req_is_store && !bus.req_is_load && st_code);
        req_width    = width_of(bus.req_alucode);
        misaligned   = (req_width == 2'd1 && bus.req_addr[0]) ||
                       (req_width == 2'd2 && bus.req_addr[1:0] != 2'b00);
        out_of_range = |bus.req_addr[31:ADDR_W];
        // illegal outranks misaligned, which outranks out-of-range
        if (!legal)            req_cause = 2'b11;
        else if (misaligned)   req_cause = 2'b01;
        else if (out_of_range) req_cause = 2'b10;
        else                   req_cause = 2'b00;
    end

    assign accept = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (req_cause != 2'b00) ? FAULT : ISSUE;
            ISSUE:   next_state = op_load ? WAIT : IDLE;
            WAIT:    next_state = RESP;
            RESP:    next_state = IDLE;
            FAULT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_code  <= '0;
            op_load  <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
            op_rd    <= '0;
            op_cause <= '0;
        end else if (accept) begin
            op_code  <= bus.req_alucode;
            op_load  <= bus.req_is_load;
            op_addr  <= bus.req_addr;
            op_wdata <= bus.req_wdata;
            op_rd    <= bus.req_rd;
            op_cause <= req_cause;
        end
    end

    // Halfword and word ops are aligned here, so one byte-granular shift serves all widths.
    assign lane = bus.mem_rdata >> {op_addr[1:0], 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_data <= '0;
        end else if (state == WAIT) begin
            case (op_code)
                ALU_LB:  load_data <= {{24{lane[7]}}, lane[7:0]};
                ALU_LBU: load_data <= {24'd0, lane[7:0]};
                ALU_LH:  load_data <= {{16{lane[15]}}, lane[15:0]};
                ALU_LHU: load_data <= {16'd0, lane[15:0]};
                default: load_data <= lane;
            endcase
        end
    end

    always_comb begin
        op_width = width_of(op_code);
        case (op_width)
            2'd0: begin
                be_calc    = 4'b0001 << op_addr[1:0];
                wdata_calc = {4{op_wdata[7:0]}};
            end
            2'd1: begin
                be_calc    = op_addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{op_wdata[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = op_wdata;
            end
        endcase
    end

    always_comb begin
        bus.req_ready = rst_n && (state == IDLE);
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = 4'b0000;
        bus.mem_wdata = '0;
        bus.mem_addr  = op_addr[ADDR_W-1:2];
        bus.wb_valid  = (state == RESP);
        bus.wb_rd     = op_rd;
        bus.wb_data   = load_data;
        bus.exc_valid = (state == FAULT);
        bus.exc_cause = op_cause;
        bus.exc_addr  = op_addr;
        if (state == ISSUE) begin
            bus.mem_re    = op_load;
            bus.mem_we    = !op_load;
            bus.mem_be    = be_calc;
            bus.mem_wdata = op_load ? 32'd0 : wdata_calc;
        end
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a byte-level reference memory and arithmetic model predict
// strobes, enables, write data, writeback values and fault causes cycle by cycle.
module tb_lsu_ctrl;
    localparam int ADDR_W = 17;
    localparam int NWORDS = 1 << (ADDR_W - 2);

    localparam logic [5:0] ALU_LB  = 6'd18;
    localparam logic [5:0] ALU_LH  = 6'd19;
    localparam logic [5:0] ALU_LW  = 6'd20;
    localparam logic [5:0] ALU_LBU = 6'd21;
    localparam logic [5:0] ALU_LHU = 6'd22;
    localparam logic [5:0] ALU_SB  = 6'd23;
    localparam logic [5:0] ALU_SH  = 6'd24;
    localparam logic [5:0] ALU_SW  = 6'd25;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    lsu_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int          checks = 0;
    int          errors = 0;
    bit          quiet_mode = 1'b0;
    logic [31:0] dmem    [NWORDS];
    logic [31:0] ref_mem [NWORDS];
    logic [31:0] exp_q   [$];

    // data memory behaviour seen by the DUT
    always @(negedge clk) begin
        if (bus.mem_we)
            for (int i = 0; i < 4; i++)
                if (bus.mem_be[i]) dmem[bus.mem_addr][8*i +: 8] = bus.mem_wdata[8*i +: 8];
        if (bus.mem_re) bus.mem_rdata = dmem[bus.mem_addr];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (bus.mem_re && bus.mem_we) begin
                errors++;
                $display("FAIL strobe_overlap: mem_re=%b mem_we=%b, required not both high", bus.mem_re, bus.mem_we);
            end
            if (quiet_mode) begin
                checks++;
                if ({bus.mem_re, bus.mem_we, bus.wb_valid, bus.exc_valid} !== 4'b0000) begin
                    errors++;
                    $display("FAIL quiet_after_reset: re/we/wb/exc=%b, required 0000",
                             {bus.mem_re, bus.mem_we, bus.wb_valid, bus.exc_valid});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [5:0] c);
        if (c == ALU_LB || c == ALU_LBU || c == ALU_SB) return 1;
        if (c == ALU_LH || c == ALU_LHU || c == ALU_SH) return 2;
        return 4;
    endfunction

    function automatic logic [1:0] model_cause(input logic [5:0] c, input bit ld, input bit st,
                                               input logic [31:0] addr);
        bit is_ld_code = (c == ALU_LB || c == ALU_LH || c == ALU_LW || c == ALU_LBU || c == ALU_LHU);
        bit is_st_code = (c == ALU_SB || c == ALU_SH || c == ALU_SW);
        if (!((ld && !st && is_ld_code) || (st && !ld && is_st_code))) return 2'b11;
        if (addr % op_size(c) != 0) return 2'b01;
        if (addr >= (32'd1 << ADDR_W)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [3:0] model_be(input logic [5:0] c, input logic [31:0] addr);
        int v = ((1 << op_size(c)) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [5:0] c, input logic [31:0] d);
        if (op_size(c) == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
        if (op_size(c) == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] c, input logic [31:0] word,
                                               input logic [31:0] addr);
        int          sz = op_size(c);
        bit          sgn = (c == ALU_LB || c == ALU_LH);
        logic [63:0] v;
        v = {32'd0, word} >> (8 * (addr % 4));
        v = v % (64'd1 << (8 * sz));
        if (sgn && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [5:0] c, input logic [31:0] addr, input logic [31:0] d);
        for (int b = 0; b < op_size(c); b++)
            ref_mem[addr / 4][8 * (addr % 4 + b) +: 8] = d[8*b +: 8];
    endtask

    task automatic set_word(input int widx, input logic [31:0] val);
        dmem[widx]    = val;
        ref_mem[widx] = val;
    endtask

    task automatic drive_req(input logic [5:0] c, input bit ld, input bit st, input logic [31:0] addr,
                             input logic [31:0] d, input logic [4:0] rd);
        bus.req_valid    = 1'b1;
        bus.req_alucode  = c;
        bus.req_is_load  = ld;
        bus.req_is_store = st;
        bus.req_addr     = addr;
        bus.req_wdata    = d;
        bus.req_rd       = rd;
    endtask

    task automatic scramble_req();
        bus.req_valid    = 1'b0;
        bus.req_alucode  = 6'($urandom);
        bus.req_is_load  = 1'($urandom);
        bus.req_is_store = 1'($urandom);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        bus.req_rd       = 5'($urandom);
    endtask

    // One complete operation, checked cycle by cycle from T+1 onwards.
    task automatic do_op(input logic [5:0] c, input bit ld, input bit st, input logic [31:0] addr,
                         input logic [31:0] d, input logic [4:0] rd, input string tag);
        logic [1:0]        cause = model_cause(c, ld, st, addr);
        logic [ADDR_W-3:0] exp_ma = (ADDR_W-2)'(addr >> 2);
        logic [31:0]       exp_d;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_before: got %b required 1", tag, bus.req_ready);
        end
        drive_req(c, ld, st, addr, d, rd);
        @(posedge clk); #1;
        scramble_req();
        @(negedge clk);
        if (cause != 2'b00) begin
            checks++;
            if ({bus.exc_valid, bus.exc_cause, bus.exc_addr} !== {1'b1, cause, addr}) begin
                errors++; $display("FAIL %s fault: got v=%b cause=%b addr=%h required v=1 cause=%b addr=%h",
                                   tag, bus.exc_valid, bus.exc_cause, bus.exc_addr, cause, addr);
            end
            checks++;
            if ({bus.mem_re, bus.mem_we} !== 2'b00) begin
                errors++; $display("FAIL %s fault_strobe: got re/we=%b%b required 00", tag, bus.mem_re, bus.mem_we);
            end
            @(negedge clk);
            checks++;
            if ({bus.exc_valid, bus.req_ready} !== 2'b01) begin
                errors++; $display("FAIL %s fault_end: got exc/ready=%b%b required 01", tag, bus.exc_valid, bus.req_ready);
            end
        end else if (st) begin
            checks++;
            if ({bus.mem_we, bus.mem_re, bus.mem_be, bus.mem_addr, bus.mem_wdata} !==
                {2'b10, model_be(c, addr), exp_ma, model_wdata(c, d)}) begin
                errors++; $display("FAIL %s store_issue: got we=%b re=%b be=%b addr=%h wdata=%h required we=1 re=0 be=%b addr=%h wdata=%h",
                                   tag, bus.mem_we, bus.mem_re, bus.mem_be, bus.mem_addr, bus.mem_wdata,
                                   model_be(c, addr), exp_ma, model_wdata(c, d));
            end
            model_store(c, addr, d);
            @(negedge clk);
            checks++;
            if ({bus.mem_we, bus.req_ready} !== 2'b01) begin
                errors++; $display("FAIL %s store_end: got we/ready=%b%b required 01", tag, bus.mem_we, bus.req_ready);
            end
        end else begin
            exp_q.push_back(model_load(c, ref_mem[addr / 4], addr));
            checks++;
            if ({bus.mem_re, bus.mem_we, bus.mem_be, bus.mem_addr} !== {2'b10, model_be(c, addr), exp_ma}) begin
                errors++; $display("FAIL %s load_issue: got re=%b we=%b be=%b addr=%h required re=1 we=0 be=%b addr=%h",
                                   tag, bus.mem_re, bus.mem_we, bus.mem_be, bus.mem_addr, model_be(c, addr), exp_ma);
            end
            @(negedge clk);
            checks++;
            if ({bus.mem_re, bus.wb_valid, bus.req_ready} !== 3'b000) begin
                errors++; $display("FAIL %s load_wait: got re/wb/ready=%b%b%b required 000",
                                   tag, bus.mem_re, bus.wb_valid, bus.req_ready);
            end
            @(negedge clk);
            exp_d = exp_q.pop_front();
            checks++;
            if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, rd, exp_d}) begin
                errors++; $display("FAIL %s load_wb: got v=%b rd=%0d data=%h required v=1 rd=%0d data=%h",
                                   tag, bus.wb_valid, bus.wb_rd, bus.wb_data, rd, exp_d);
            end
            @(negedge clk);
            checks++;
            if ({bus.wb_valid, bus.req_ready} !== 2'b01) begin
                errors++; $display("FAIL %s load_end: got wb/ready=%b%b required 01", tag, bus.wb_valid, bus.req_ready);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({bus.req_ready, bus.mem_re, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
             bus.wb_valid, bus.wb_rd, bus.wb_data, bus.exc_valid, bus.exc_cause, bus.exc_addr} !== '0) begin
            errors++;
            $display("FAIL %s all_zero: ready=%b re=%b we=%b be=%b addr=%h wdata=%h wb=%b rd=%0d data=%h exc=%b cause=%b eaddr=%h, required all 0",
                     tag, bus.req_ready, bus.mem_re, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
                     bus.wb_valid, bus.wb_rd, bus.wb_data, bus.exc_valid, bus.exc_cause, bus.exc_addr);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release ready: got %b required 1", bus.req_ready);
        end
    endtask

    task automatic test_directed();
        do_op(ALU_SW, 0, 1, 32'h100, 32'hDEAD_BEEF, 5'd0, "sw_0x100");
        do_op(ALU_SB, 0, 1, 32'h103, 32'h0000_00A5, 5'd0, "sb_0x103");
        do_op(ALU_LW, 1, 0, 32'h100, 32'h0, 5'd9, "lw_after_sb");
        set_word(32'h40, 32'hA500_0000);
        do_op(ALU_LB,  1, 0, 32'h103, 32'h0, 5'd3, "lb_0x103");
        do_op(ALU_LBU, 1, 0, 32'h103, 32'h0, 5'd4, "lbu_0x103");
        set_word(32'h80, 32'h8001_1234);
        do_op(ALU_LH,  1, 0, 32'h202, 32'h0, 5'd5, "lh_0x202");
        do_op(ALU_LHU, 1, 0, 32'h202, 32'h0, 5'd0, "lhu_0x202_rd0");
        do_op(ALU_LH,  1, 0, 32'h200, 32'h0, 5'd6, "lh_0x200");
    endtask

    task automatic test_faults();
        do_op(ALU_LW, 1, 0, 32'h102,   32'h0, 5'd1, "lw_misaligned");
        do_op(ALU_SH, 0, 1, 32'h001,   32'h1234, 5'd0, "sh_misaligned");
        do_op(ALU_LW, 1, 0, 32'h20000, 32'h0, 5'd1, "lw_out_of_range");
        do_op(ALU_SW, 1, 1, 32'h100,   32'h0, 5'd1, "both_load_store");
        do_op(ALU_SW, 1, 0, 32'h100,   32'h0, 5'd1, "load_with_store_code");
        do_op(ALU_LH, 1, 1, 32'h001,   32'h0, 5'd1, "illegal_over_misaligned");
        do_op(ALU_LW, 1, 0, 32'h20002, 32'h0, 5'd1, "misaligned_over_range");
        do_op(ALU_SB, 0, 1, 32'hFFFF_FFFF, 32'h0, 5'd1, "sb_out_of_range");
    endtask

    task automatic test_back_to_back();
        logic [31:0] da = $urandom;
        logic [31:0] db = $urandom;
        @(negedge clk);
        drive_req(ALU_SW, 0, 1, 32'h300, da, 5'd0);
        @(posedge clk); #1;
        drive_req(ALU_SH, 0, 1, 32'h306, db, 5'd0);
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b01, 15'h0C0, da}) begin
            errors++; $display("FAIL b2b_first: got ready=%b we=%b addr=%h wdata=%h required ready=0 we=1 addr=0c0 wdata=%h",
                               bus.req_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, da);
        end
        model_store(ALU_SW, 32'h300, da);
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.mem_we} !== 2'b10) begin
            errors++; $display("FAIL b2b_gap: got ready/we=%b%b required 10", bus.req_ready, bus.mem_we);
        end
        @(posedge clk); #1;
        scramble_req();
        @(negedge clk);
        checks++;
        if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== {1'b1, 4'b1100, 15'h0C1, {2{db[15:0]}}}) begin
            errors++; $display("FAIL b2b_second: got we=%b be=%b addr=%h wdata=%h required we=1 be=1100 addr=0c1 wdata=%h",
                               bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, {2{db[15:0]}});
        end
        model_store(ALU_SH, 32'h306, db);
        do_op(ALU_LW, 1, 0, 32'h300, 32'h0, 5'd7, "b2b_readback0");
        do_op(ALU_LW, 1, 0, 32'h304, 32'h0, 5'd8, "b2b_readback1");
    endtask

    task automatic test_reset_mid_op();
        // reset while a load sits in WAIT
        @(negedge clk);
        drive_req(ALU_LW, 1, 0, 32'h104, 32'h0, 5'd12);
        @(posedge clk); #1;
        scramble_req();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_in_wait");
        @(negedge clk);
        rst_n = 1'b1;
        quiet_mode = 1'b1;
        repeat (4) @(negedge clk);
        quiet_mode = 1'b0;
        // reset while a store strobe is high
        drive_req(ALU_SW, 0, 1, 32'h108, 32'h1234_5678, 5'd0);
        @(posedge clk); #1;
        scramble_req();
        @(negedge clk);
        checks++;
        if (bus.mem_we !== 1'b1) begin
            errors++; $display("FAIL reset_in_issue pre: got mem_we=%b required 1", bus.mem_we);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_we, bus.mem_re} !== 2'b00) begin
            errors++; $display("FAIL reset_in_issue async: got we/re=%b%b required 00", bus.mem_we, bus.mem_re);
        end
        @(negedge clk);
        rst_n = 1'b1;
        quiet_mode = 1'b1;
        repeat (3) @(negedge clk);
        quiet_mode = 1'b0;
        do_op(ALU_SW, 0, 1, 32'h10C, 32'hCAFE_F00D, 5'd0, "sw_after_reset");
        do_op(ALU_LW, 1, 0, 32'h10C, 32'h0, 5'd2, "lw_after_reset");
    endtask

    task automatic test_random(input int n);
        logic [5:0]  codes [9] = '{ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW, 6'd0};
        for (int k = 0; k < n; k++) begin
            int          idx  = $urandom_range(0, 8);
            bit          ld   = (idx < 5);
            bit          st   = (idx >= 5 && idx < 8);
            logic [31:0] addr = (32'h400 + 32'($urandom_range(0, 31))) * 4 + 32'($urandom_range(0, 3));
            if (idx == 8) begin
                ld = 1'($urandom);
                st = 1'($urandom);
            end
            if ($urandom_range(0, 9) == 0) begin
                ld = 1'b1;
                st = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) addr = addr | (32'($urandom_range(1, 16'hFFFF)) << ADDR_W);
            do_op(codes[idx], ld, st, addr, $urandom, 5'($urandom), $sformatf("rand%0d", k));
        end
    endtask

    initial begin
        for (int i = 0; i < NWORDS; i++) set_word(i, $urandom);
        scramble_req();
        test_reset();
        test_directed();
        test_faults();
        test_back_to_back();
        test_reset_mid_op();
        test_random(80);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
